// File: rtl/rs_multi.sv
// Two-wide reservation station: dual dispatch, dual-CDB wakeup, oldest-first issue
// to ALU/MULT/MEM classes with at most one issue per class per cycle.
module rs_multi #(
   parameter int                    RS_SIZE     = 16,
   parameter int                    PRF_W       = 6,
   parameter int                    ROB_W       = 5,
   parameter int                    DATA_W      = 64,
   parameter int                    ALU_FUNC_W  = 4,
   parameter logic [ALU_FUNC_W-1:0] ALU_DEFAULT = '0
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             rs_flush,
   input  logic [1:0]                       rs_load_in,
   input  logic [1:0][PRF_W-1:0]            rs_dest_in,
   input  logic [1:0][DATA_W-1:0]           rs_opa_in,
   input  logic [1:0][DATA_W-1:0]           rs_opb_in,
   input  logic [1:0]                       rs_opa_valid,
   input  logic [1:0]                       rs_opb_valid,
   input  logic [1:0][5:0]                  rs_op_type_in,
   input  logic [1:0][ALU_FUNC_W-1:0]       rs_alu_func_in,
   input  logic [1:0][1:0]                  rs_fu_class_in,
   input  logic [1:0][ROB_W-1:0]            rs_rob_idx_in,
   input  logic [1:0]                       rs_cdb_valid,
   input  logic [1:0][PRF_W-1:0]            rs_cdb_tag,
   input  logic [1:0][DATA_W-1:0]           rs_cdb_in,
   input  logic [2:0]                       fu_available,
   output logic [1:0]                       rs_out_valid,
   output logic [1:0][DATA_W-1:0]           rs_opa_out,
   output logic [1:0][DATA_W-1:0]           rs_opb_out,
   output logic [1:0][PRF_W-1:0]            rs_dest_tag_out,
   output logic [1:0][ROB_W-1:0]            rs_rob_idx_out,
   output logic [1:0][5:0]                  rs_op_type_out,
   output logic [1:0][ALU_FUNC_W-1:0]       rs_alu_func_out,
   output logic [1:0][1:0]                  rs_fu_class_out,
   output logic [$clog2(RS_SIZE):0]         rs_free_cnt,
   output logic                             rs_full
);

   localparam int IDX_W = $clog2(RS_SIZE);
   localparam int CNT_W = IDX_W + 1;

   typedef struct packed {
      logic                  valid;
      logic [DATA_W-1:0]     opa;
      logic                  opa_rdy;
      logic [DATA_W-1:0]     opb;
      logic                  opb_rdy;
      logic [PRF_W-1:0]      dest;
      logic [ROB_W-1:0]      rob;
      logic [5:0]            op_type;
      logic [ALU_FUNC_W-1:0] alu_func;
      logic [1:0]            fu_class;
   } entry_t;

   // Dispatch contract: there is no ready back-pressure. Each slot with rs_load_in
   // set is taken this edge if a free entry exists; the dispatcher throttles on
   // rs_full (free < 2) so neither slot is ever dropped.
   entry_t ent_q [RS_SIZE];
   entry_t ent_d [RS_SIZE];
   // older_q[j][i] is set when entry j was dispatched before entry i.
   logic [RS_SIZE-1:0][RS_SIZE-1:0] older_q, older_d;

   logic [1:0]                 out_valid_q, out_valid_d;
   logic [1:0][DATA_W-1:0]     opa_out_q, opa_out_d, opb_out_q, opb_out_d;
   logic [1:0][PRF_W-1:0]      dest_out_q, dest_out_d;
   logic [1:0][ROB_W-1:0]      rob_out_q, rob_out_d;
   logic [1:0][5:0]            op_type_out_q, op_type_out_d;
   logic [1:0][ALU_FUNC_W-1:0] alu_func_out_q, alu_func_out_d;
   logic [1:0][1:0]            fu_class_out_q, fu_class_out_d;

   logic [RS_SIZE-1:0] elig, elig1;
   logic [3:0]         fu_ok;
   logic [IDX_W:0]     sel0, sel1;
   logic               sel0_vld, sel1_vld;
   logic [IDX_W-1:0]   sel0_idx, sel1_idx;
   logic               first_vld, second_vld;
   logic [IDX_W-1:0]   first_idx, second_idx;
   logic [1:0]         dsp_ok;
   logic [1:0][IDX_W-1:0] dsp_idx;
   logic [CNT_W-1:0]   free_cnt;

   // Returns {ready, value}; CDB0 wins when both buses carry the same tag.
   function automatic logic [DATA_W:0] capture(
      input logic [DATA_W-1:0]          v,
      input logic                       rdy,
      input logic [1:0]                 cv,
      input logic [1:0][PRF_W-1:0]      ct,
      input logic [1:0][DATA_W-1:0]     cd
   );
      logic [DATA_W:0] r;
      r = {rdy, v};
      if (!rdy) begin
         if (cv[0] && (ct[0] == v[PRF_W-1:0]))      r = {1'b1, cd[0]};
         else if (cv[1] && (ct[1] == v[PRF_W-1:0])) r = {1'b1, cd[1]};
      end
      return r;
   endfunction

   function automatic logic [IDX_W:0] pick_oldest(
      input logic [RS_SIZE-1:0]              m,
      input logic [RS_SIZE-1:0][RS_SIZE-1:0] older
   );
      logic [IDX_W:0] r;
      logic           beaten;
      r = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         beaten = 1'b0;
         for (int j = 0; j < RS_SIZE; j++) begin
            if ((j != i) && m[j] && older[j][i]) beaten = 1'b1;
         end
         if (m[i] && !beaten && !r[IDX_W]) r = {1'b1, IDX_W'(i)};
      end
      return r;
   endfunction

   always_comb begin
      fu_ok = {1'b0, fu_available};
      elig  = '0;
      elig1 = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         elig[i] = ent_q[i].valid && ent_q[i].opa_rdy && ent_q[i].opb_rdy &&
                   fu_ok[ent_q[i].fu_class];
      end
      sel0     = pick_oldest(elig, older_q);
      sel0_vld = sel0[IDX_W];
      sel0_idx = sel0[IDX_W-1:0];
      for (int i = 0; i < RS_SIZE; i++) begin
         elig1[i] = elig[i] && sel0_vld && (ent_q[i].fu_class != ent_q[sel0_idx].fu_class);
      end
      sel1     = pick_oldest(elig1, older_q);
      sel1_vld = sel1[IDX_W];
      sel1_idx = sel1[IDX_W-1:0];
   end

   // Free entries come from registered state only, so same-edge issues are not reused.
   always_comb begin
      first_vld  = 1'b0;
      second_vld = 1'b0;
      first_idx  = '0;
      second_idx = '0;
      free_cnt   = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (!ent_q[i].valid) begin
            free_cnt = free_cnt + CNT_W'(1);
            if (!first_vld) begin
               first_vld = 1'b1;
               first_idx = IDX_W'(i);
            end else if (!second_vld) begin
               second_vld = 1'b1;
               second_idx = IDX_W'(i);
            end
         end
      end
      dsp_ok[0]  = rs_load_in[0] && first_vld;
      dsp_idx[0] = first_idx;
      dsp_ok[1]  = rs_load_in[1] && (rs_load_in[0] ? second_vld : first_vld);
      dsp_idx[1] = rs_load_in[0] ? second_idx : first_idx;
   end

   always_comb begin
      ent_d          = ent_q;
      older_d        = older_q;
      out_valid_d    = '0;
      opa_out_d      = '0;
      opb_out_d      = '0;
      dest_out_d     = '0;
      rob_out_d      = '0;
      op_type_out_d  = '0;
      alu_func_out_d = {2{ALU_DEFAULT}};
      fu_class_out_d = '0;

      for (int i = 0; i < RS_SIZE; i++) begin
         {ent_d[i].opa_rdy, ent_d[i].opa} =
            capture(ent_q[i].opa, ent_q[i].opa_rdy, rs_cdb_valid, rs_cdb_tag, rs_cdb_in);
         {ent_d[i].opb_rdy, ent_d[i].opb} =
            capture(ent_q[i].opb, ent_q[i].opb_rdy, rs_cdb_valid, rs_cdb_tag, rs_cdb_in);
      end

      for (int p = 0; p < 2; p++) begin
         if ((p == 0) ? sel0_vld : sel1_vld) begin
            out_valid_d[p]    = 1'b1;
            opa_out_d[p]      = ent_q[(p == 0) ? sel0_idx : sel1_idx].opa;
            opb_out_d[p]      = ent_q[(p == 0) ? sel0_idx : sel1_idx].opb;
            dest_out_d[p]     = ent_q[(p == 0) ? sel0_idx : sel1_idx].dest;
            rob_out_d[p]      = ent_q[(p == 0) ? sel0_idx : sel1_idx].rob;
            op_type_out_d[p]  = ent_q[(p == 0) ? sel0_idx : sel1_idx].op_type;
            alu_func_out_d[p] = ent_q[(p == 0) ? sel0_idx : sel1_idx].alu_func;
            fu_class_out_d[p] = ent_q[(p == 0) ? sel0_idx : sel1_idx].fu_class;
            ent_d[(p == 0) ? sel0_idx : sel1_idx].valid = 1'b0;
         end
      end

      // Slot 0 is written first so slot 1 ends up younger in the age matrix.
      for (int s = 0; s < 2; s++) begin
         if (dsp_ok[s]) begin
            ent_d[dsp_idx[s]].valid = 1'b1;
            {ent_d[dsp_idx[s]].opa_rdy, ent_d[dsp_idx[s]].opa} =
               capture(rs_opa_in[s], rs_opa_valid[s], rs_cdb_valid, rs_cdb_tag, rs_cdb_in);
            {ent_d[dsp_idx[s]].opb_rdy, ent_d[dsp_idx[s]].opb} =
               capture(rs_opb_in[s], rs_opb_valid[s], rs_cdb_valid, rs_cdb_tag, rs_cdb_in);
            ent_d[dsp_idx[s]].dest     = rs_dest_in[s];
            ent_d[dsp_idx[s]].rob      = rs_rob_idx_in[s];
            ent_d[dsp_idx[s]].op_type  = rs_op_type_in[s];
            ent_d[dsp_idx[s]].alu_func = rs_alu_func_in[s];
            ent_d[dsp_idx[s]].fu_class = rs_fu_class_in[s];
            for (int j = 0; j < RS_SIZE; j++) older_d[j][dsp_idx[s]] = 1'b1;
            older_d[dsp_idx[s]] = '0;
         end
      end

      if (rs_flush) begin
         for (int i = 0; i < RS_SIZE; i++) ent_d[i].valid = 1'b0;
         out_valid_d    = '0;
         opa_out_d      = '0;
         opb_out_d      = '0;
         dest_out_d     = '0;
         rob_out_d      = '0;
         op_type_out_d  = '0;
         alu_func_out_d = {2{ALU_DEFAULT}};
         fu_class_out_d = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
         older_q        <= '0;
         out_valid_q    <= '0;
         opa_out_q      <= '0;
         opb_out_q      <= '0;
         dest_out_q     <= '0;
         rob_out_q      <= '0;
         op_type_out_q  <= '0;
         alu_func_out_q <= {2{ALU_DEFAULT}};
         fu_class_out_q <= '0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
         older_q        <= older_d;
         out_valid_q    <= out_valid_d;
         opa_out_q      <= opa_out_d;
         opb_out_q      <= opb_out_d;
         dest_out_q     <= dest_out_d;
         rob_out_q      <= rob_out_d;
         op_type_out_q  <= op_type_out_d;
         alu_func_out_q <= alu_func_out_d;
         fu_class_out_q <= fu_class_out_d;
      end
   end

   assign rs_out_valid    = out_valid_q;
   assign rs_opa_out      = opa_out_q;
   assign rs_opb_out      = opb_out_q;
   assign rs_dest_tag_out = dest_out_q;
   assign rs_rob_idx_out  = rob_out_q;
   assign rs_op_type_out  = op_type_out_q;
   assign rs_alu_func_out = alu_func_out_q;
   assign rs_fu_class_out = fu_class_out_q;
   assign rs_free_cnt     = free_cnt;
   assign rs_full         = (free_cnt < CNT_W'(2));

endmodule

// File: doc/rs_multi.md
Name: rs_multi

Overview:
- Parametrised multi-entry reservation station for the 2-way superscalar out-of-order core.
- Accepts up to two renamed instructions per cycle and wakes source operands from two CDBs.
- Issues up to two ready instructions per cycle, oldest-first, to the ALU, MULT and MEM functional-unit classes.
- Adds a global flush for branch mispredict recovery.

Parameters:
- RS_SIZE, 16, number of entries (power of 2, ≥4).
- PRF_W, 6, physical register tag width.
- ROB_W, 5, ROB index width.
- DATA_W, 64, operand width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rs_flush  in  1  mispredict flush; clears all entries.
- rs_load_in  in  2  per-slot dispatch request; slot 0 is older than slot 1.
- rs_dest_in  in  2xPRF_W  destination tags.
- rs_opa_in, rs_opb_in  in  2xDATA_W each  operand value, or tag in the low PRF_W bits when the operand is not valid.
- rs_opa_valid, rs_opb_valid  in  2 each  operand holds a value (1) or a tag (0).
- rs_op_type_in  in  2x6  op type.
- rs_alu_func_in  in  2xALU_FUNC  ALU function.
- rs_fu_class_in  in  2x2  0=ALU, 1=MULT, 2=MEM (3 illegal).
- rs_rob_idx_in  in  2xROB_W  ROB index.
- rs_cdb_valid  in  2  CDB valid bits.
- rs_cdb_tag  in  2xPRF_W  CDB tags.
- rs_cdb_in  in  2xDATA_W  CDB data.
- fu_available  in  3  per-class availability {MEM, MULT, ALU}.
- rs_out_valid  out  2  issue port valid.
- rs_opa_out, rs_opb_out  out  2xDATA_W each  issued operands.
- rs_dest_tag_out  out  2xPRF_W  issued destination tags.
- rs_rob_idx_out  out  2xROB_W  issued ROB indices.
- rs_op_type_out  out  2x6  issued op types.
- rs_alu_func_out  out  2xALU_FUNC  issued ALU functions.
- rs_fu_class_out  out  2x2  issued FU classes.
- rs_free_cnt  out  $clog2(RS_SIZE)+1  number of free entries.
- rs_full  out  1  asserted when rs_free_cnt<2.

Behaviour:
- Reset (async) and flush (sync, at the edge):
  - All entries become invalid.
  - All outputs go to 0, rs_alu_func_out to ALU_DEFAULT.
  - rs_free_cnt=RS_SIZE, rs_full=0.
  - Flush overrides dispatch and issue in the same cycle.
- Entry state: valid, opa/opb value-or-tag plus ready bits, dest, rob_idx, op_type, alu_func, fu_class, age.
- Dispatch:
  - At the edge, each slot with rs_load_in set is written into the lowest-indexed free entry; slot 0 takes the lower entry.
  - Entries freed by issue in the same edge are not reusable until the next cycle.
  - If free space is short, slot 0 has priority and an unaccepted slot is dropped. The dispatcher must respect rs_full; the bench asserts it never drops.
- Wakeup:
  - Each cycle, any not-ready operand whose tag equals a valid CDB tag captures that CDB's data and sets its ready bit at the edge.
  - A dispatching operand whose tag matches a same-cycle CDB is written ready, holding the CDB data.
  - If both CDBs match the same tag, CDB0 wins.
- Eligibility: valid, both operands ready in the registered state, and fu_available[fu_class]=1. The wakeup-to-issue latency is therefore at least 1 cycle.
- Selection:
  - Port 0 takes the oldest eligible entry.
  - Port 1 takes the oldest eligible entry whose FU class differs from port 0's.
  - At most one issue per FU class per cycle.
  - Age is dispatch order. An age matrix or a monotonic stamp is acceptable; the result must be identical.
- Issue:
  - Selected entry fields are registered to the port outputs at the edge and the entry is freed.
  - rs_out_valid is high for exactly one cycle per issue.
  - On an idle port, all fields are 0 and alu_func is ALU_DEFAULT.
  - The minimum latency from dispatch edge to output valid is 1 cycle: dispatch at edge N, outputs valid after edge N+1.
- rs_free_cnt and rs_full are derived from registered entry state: free_next = free + issued − accepted.
- Operands given as values (valid=1) are never modified by the CDB.
- fu_class=3 is never eligible; the bench flags it as an error.

Test Plan:
- Reset, then dispatch slot0 MULT (opa=32, opb=26, dest=1, rob=0), all FUs available → port0 valid next cycle with 32/26/dest 1/rob 0; rs_free_cnt returns to 16.
- Dispatch ADD with opa tag 1 (not ready), opb=46, rob=1 → no issue; CDB0 tag=1 data=832 with ALU available → next cycle port0 issues opa=832, opb=46.
- Two ALU instructions at rob 3 and 4, both ready, plus a MEM at rob 5, all available → cycle 1: port0=rob3 and port1=rob5; cycle 2: port0=rob4.
- Fill 15 entries with operands waiting on tag 9 → rs_full=1 and rs_free_cnt=1; CDB1 broadcasts tag 9 with only ALU available → ALU entries drain one per cycle in dispatch order.
- With 6 entries pending, assert rs_flush while dispatching 2 → next cycle rs_free_cnt=16 and no issue; reset asserted mid-cycle clears outputs immediately.
- Dispatch an operand whose tag matches CDB0 and CDB1 in the same cycle (data 300/400) → issues with 300.
